// File: rtl/ttl_counter_sync.sv
// Bank of independent 74161/74163/74169-style counters clocked by emulated TTL strobes.
// Optional build macro TTL_COUNTER_RCO_REG_EN registers RCO, aligned with the new Q value.
module ttl_counter_sync #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned BLOCKS    = 1,
  parameter bit          CLR_SYNC  = 1'b0,
  parameter bit          UPDOWN    = 1'b0,
  parameter bit          EDGE_RISE = 1'b1
) (
  input  logic                      Clk,
  input  logic                      RST,
  input  logic [BLOCKS-1:0]         Cen,
  input  logic [BLOCKS-1:0]         CLRn,
  input  logic [BLOCKS-1:0]         LOADn,
  input  logic [BLOCKS-1:0]         ENP,
  input  logic [BLOCKS-1:0]         ENT,
  input  logic [BLOCKS-1:0]         UD,
  input  logic [BLOCKS*WIDTH-1:0]   D,
  output logic [BLOCKS*WIDTH-1:0]   Q,
  output logic [BLOCKS-1:0]         RCO
);

  // Terminal count: all-ones when counting up, zero when counting down.
  function automatic logic is_terminal(input logic [WIDTH-1:0] v, input logic up);
    return up ? (v == {WIDTH{1'b1}}) : (v == {WIDTH{1'b0}});
  endfunction

  for (genvar i = 0; i < BLOCKS; i++) begin : g_cnt
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] d_slice;
    logic             last_cen_q;
    logic             edge_c;
    logic             up_c;
    logic             clr_c;

    assign d_slice = D[i*WIDTH +: WIDTH];

    // Edge detect, direction select and clear/load/count priority.
    always_comb begin
      edge_c = EDGE_RISE ? (!last_cen_q && Cen[i]) : (last_cen_q && !Cen[i]);
      up_c   = !UPDOWN || UD[i];
      clr_c  = !CLRn[i] && (!CLR_SYNC || edge_c);
      cnt_d  = cnt_q;
      if (clr_c) begin
        cnt_d = '0;
      end else if (edge_c && !LOADn[i]) begin
        cnt_d = d_slice;
      end else if (edge_c && ENP[i] && ENT[i]) begin
        cnt_d = up_c ? (cnt_q + WIDTH'(1)) : (cnt_q - WIDTH'(1));
      end
    end

    // last_cen resets to the idle level so a static strobe never looks like an edge.
    always_ff @(posedge Clk or posedge RST) begin
      if (RST) begin
        cnt_q      <= '0;
        last_cen_q <= EDGE_RISE;
      end else begin
        cnt_q      <= cnt_d;
        last_cen_q <= Cen[i];
      end
    end

    assign Q[i*WIDTH +: WIDTH] = cnt_q;

`ifdef TTL_COUNTER_RCO_REG_EN
    logic rco_q;

    always_ff @(posedge Clk or posedge RST) begin
      if (RST) begin
        rco_q <= 1'b0;
      end else begin
        rco_q <= ENT[i] && is_terminal(cnt_d, up_c);
      end
    end

    assign RCO[i] = rco_q;
`else
    // Held low while reset is asserted, even when a down counter sits at zero.
    assign RCO[i] = !RST && ENT[i] && is_terminal(cnt_q, up_c);
`endif
  end

endmodule

// File: doc/ttl_counter_sync.md
# ttl_counter_sync

Parametrised, cascadable synchronous binary counter bank that emulates the 74161/74163/74169 family inside a single fast system clock. The TTL clock of each counter is supplied as a clock-enable strobe, and the counter acts on a selectable edge of that strobe. Arcade board recreations use it for video timing chains, sprite line counters and address generators. It replaces discrete per-chip counter modules with one configurable block.

## Interface
- WIDTH, 4: bits per counter.
- BLOCKS, 1: number of independent counters.
- CLR_SYNC, 0: 0 = clear acts on any Clk edge (pseudo-asynchronous, 74161); 1 = clear acts only on an emulated edge (74163).
- UPDOWN, 0: 1 = UD input selects direction (74169); 0 = up only, UD ignored.
- EDGE_RISE, 1: 1 = act on rising edge of Cen; 0 = act on falling edge.

Ports:
- Clk  input  1  system clock; all state updates on posedge.
- RST  input  1  asynchronous, active-high reset.
- Cen  input  BLOCKS  emulated TTL clock per counter.
- CLRn  input  BLOCKS  active-low clear.
- LOADn  input  BLOCKS  active-low parallel load.
- ENP  input  BLOCKS  count enable P.
- ENT  input  BLOCKS  count enable T; also gates RCO.
- UD  input  BLOCKS  1 = up, 0 = down. Used only when UPDOWN=1.
- D  input  BLOCKS*WIDTH  load data; counter i uses D[i*WIDTH +: WIDTH].
- Q  output  BLOCKS*WIDTH  counter values, packed the same way as D.
- RCO  output  BLOCKS  ripple carry out.

## Operation
- **Per-counter edge detect:** last_cen[i] <= Cen[i] on every Clk.
  - Rising edge: !last_cen & Cen.
  - Falling edge: last_cen & !Cen.
- **Priority within each counter, evaluated each Clk:**
  1. CLRn low.
     - CLR_SYNC=0: Q <= 0 regardless of Cen.
     - CLR_SYNC=1: Q <= 0 only when the emulated edge is detected.
  2. Emulated edge detected and LOADn low: Q <= D slice.
  3. Emulated edge detected and ENP & ENT high: Q <= Q+1 when up, Q-1 when down. Arithmetic is modulo 2^WIDTH, so all-ones wraps to 0 and 0 wraps to all-ones.
  4. Otherwise hold.
- Direction is up when UPDOWN=0 or UD=1.
- **RCO[i]** = ENT[i] & (up ? Q == all-ones : Q == 0).
- **Cascading** is done outside the block: wire RCO of the lower counter to ENT of the upper, and share Cen between them.
- Counters are fully independent. The generate loop covers 1 to BLOCKS counters with no cross-talk.

## Timing
- **On reset assertion:**
  - Q = 0 and RCO = 0, immediately and asynchronously.
  - last_cen = EDGE_RISE, so a static Cen after release never produces a spurious edge.
- Reset deasserted mid-count: the counter restarts from 0. The first emulated edge is the first real Cen transition after release.
- Latency: Q updates at the Clk posedge on which the Cen transition is first sampled, one Clk after Cen changes. It is visible on the following cycle.
- Cen pulses shorter than one Clk period are not guaranteed to be detected.
- Control inputs (CLRn, LOADn, ENP, ENT, UD, D) are sampled on the same Clk as the detected edge.
- Combinational RCO follows Q and ENT in the same cycle.
- CLRn and LOADn both low on an edge: clear wins.
- UD change coincident with an edge: the new UD value applies.

## Configuration
- **TTL_COUNTER_RCO_REG_EN defined:** RCO is registered.
  - On every Clk, RCO[i] <= ENT[i] & terminal(Q_next[i]).
  - RCO is therefore aligned with the new Q value and glitch-free.
  - Reset value is 0.
- **Not defined:** RCO is purely combinational from the current Q and ENT, as specified in Operation.
- All other behaviour is identical in both builds.

## Test plan
- **Up count and wrap:** WIDTH=4, EDGE_RISE=1, ENP=ENT=1, 16 Cen rising edges from 0 -> Q steps 1..15 then 0. RCO=1 only while Q=15.
- **Load:** LOADn=0, D=4'hA, one Cen edge -> Q=A. ENP=0 with further edges -> Q holds at A.
- **Clear modes:** Q=5, CLRn=0 with Cen static.
  - CLR_SYNC=0: Q=0 after one Clk.
  - CLR_SYNC=1: Q stays 5 until the next Cen edge, then becomes 0.
  - CLRn=LOADn=0 on an edge -> Q=0.
- **Down count:** UPDOWN=1, UD=0, start at 1 -> 0 with RCO=1, then F. EDGE_RISE=0: only Cen falling edges advance the count.
- **Cascade:** BLOCKS=2, RCO[0] wired to ENT[1], Cen shared, 256 edges -> the combined 8-bit value counts 00..FF and wraps. Upper counter increments exactly when lower goes F->0.
- **Reset mid-count:** assert RST asynchronously at Q=7 -> Q=0 and RCO=0 immediately. After release with Cen held high, no count occurs until the next real edge.
